// File: rtl/cmov_writeback.sv
// Commit stage for MOVE/CMOV: 2-entry write queue draining into the register-file write port.
// Optional build macro CMOV_STATS_EN adds the stat_moves / stat_suppressed counters.
module cmov_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic        req_cmov,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_data,
    input  logic        flush,
    input  logic        rf_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  hz_raddr,
    output logic        hz_hit,
    output logic [31:0] hz_data,
    output logic        illegal_op
`ifdef CMOV_STATS_EN
    ,
    output logic [15:0] stat_moves,
    output logic [15:0] stat_suppressed
`endif
);

    localparam logic [5:0] OP_MOVE = 6'b110000;
    localparam logic [5:0] OP_CMOV = 6'b110001;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        head;
    logic        tail;
    logic        young;
    logic [4:0]  rd_q   [2];
    logic [31:0] data_q [2];

    logic accept;
    logic op_legal;
    logic enq;
    logic deq;

    // Handshake, enqueue qualification and drain port
    always_comb begin
        req_ready = (state != FULL) && !flush;
        accept    = req_valid && req_ready;
        op_legal  = (req_opcode == OP_MOVE) || (req_opcode == OP_CMOV);
        enq       = accept && op_legal && req_cmov && (req_rd != 5'd0);
        rf_we     = (state != EMPTY) && !rf_stall;
        deq       = rf_we;
        rf_waddr  = rd_q[head];
        rf_wdata  = data_q[head];
        young     = ~head;
    end

    // Occupancy next-state; flush overrides any enqueue/dequeue
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (enq) state_next = ONE;
                    else     state_next = EMPTY;
                end
                ONE: begin
                    if (enq && !deq)      state_next = FULL;
                    else if (!enq && deq) state_next = EMPTY;
                    else                  state_next = ONE;
                end
                FULL: begin
                    if (deq) state_next = ONE;
                    else     state_next = FULL;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Queue storage, pointers, state register and illegal-opcode pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            head       <= 1'b0;
            tail       <= 1'b0;
            illegal_op <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            state      <= state_next;
            illegal_op <= accept && !op_legal;
            if (flush) begin
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                if (deq) head <= ~head;
                if (enq) begin
                    rd_q[tail]   <= req_rd;
                    data_q[tail] <= req_data;
                    tail         <= ~tail;
                end
            end
        end
    end

    // Hazard lookup: the non-head entry is the younger one when both are valid
    always_comb begin
        hz_hit  = 1'b0;
        hz_data = 32'd0;
        if (hz_raddr != 5'd0) begin
            if ((state == FULL) && (rd_q[young] == hz_raddr)) begin
                hz_hit  = 1'b1;
                hz_data = data_q[young];
            end else if ((state != EMPTY) && (rd_q[head] == hz_raddr)) begin
                hz_hit  = 1'b1;
                hz_data = data_q[head];
            end else begin
                hz_hit  = 1'b0;
                hz_data = 32'd0;
            end
        end else begin
            hz_hit  = 1'b0;
            hz_data = 32'd0;
        end
    end

`ifdef CMOV_STATS_EN
    // Saturating commit / suppression counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_moves      <= 16'd0;
            stat_suppressed <= 16'd0;
        end else begin
            if (rf_we && (stat_moves != 16'hFFFF))
                stat_moves <= stat_moves + 16'd1;
            if (accept && op_legal && !req_cmov && (stat_suppressed != 16'hFFFF))
                stat_suppressed <= stat_suppressed + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cmov_writeback.sv
// Self-checking bench for cmov_writeback: directed scenarios plus randomized traffic vs a queue model.
module tb_cmov_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = 6'd0;
    logic        req_cmov = 1'b0;
    logic [4:0]  req_rd = 5'd0;
    logic [31:0] req_data = 32'd0;
    logic        flush = 1'b0;
    logic        rf_stall = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  hz_raddr = 5'd0;
    logic        hz_hit;
    logic [31:0] hz_data;
    logic        illegal_op;
`ifdef CMOV_STATS_EN
    logic [15:0] stat_moves;
    logic [15:0] stat_suppressed;
`endif

    localparam logic [5:0] MV = 6'b110000;
    localparam logic [5:0] CM = 6'b110001;

    cmov_writeback dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_cmov(req_cmov), .req_rd(req_rd), .req_data(req_data),
        .flush(flush), .rf_stall(rf_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hz_raddr(hz_raddr), .hz_hit(hz_hit), .hz_data(hz_data),
        .illegal_op(illegal_op)
`ifdef CMOV_STATS_EN
        , .stat_moves(stat_moves), .stat_suppressed(stat_suppressed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    logic exp_illegal = 1'b0;
    int   exp_moves = 0;
    int   exp_supp = 0;
    int   total = 0;
    int   bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic v, input logic [5:0] op, input logic c, input logic [4:0] rd,
                        input logic [31:0] d, input logic fl, input logic st, input logic [4:0] hz);
        logic e_ready, e_we, e_hit, legal, acc;
        logic [31:0] e_hd;
        @(negedge clk);
        req_valid = v; req_opcode = op; req_cmov = c; req_rd = rd; req_data = d;
        flush = fl; rf_stall = st; hz_raddr = hz;
        #1;
        e_ready = (q.size() != 2) && !fl;
        e_we    = (q.size() != 0) && !st;
        e_hit   = 1'b0;
        e_hd    = 32'd0;
        if (hz != 5'd0) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].rd == hz) begin
                    e_hit = 1'b1;
                    e_hd  = q[i].data;
                end
            end
        end
        check_val("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
        check_val("rf_we", {31'd0, rf_we}, {31'd0, e_we});
        if (e_we) begin
            check_val("rf_waddr", {27'd0, rf_waddr}, {27'd0, q[0].rd});
            check_val("rf_wdata", rf_wdata, q[0].data);
        end
        check_val("hz_hit", {31'd0, hz_hit}, {31'd0, e_hit});
        check_val("hz_data", hz_data, e_hd);
        check_val("illegal_op", {31'd0, illegal_op}, {31'd0, exp_illegal});
`ifdef CMOV_STATS_EN
        check_val("stat_moves", {16'd0, stat_moves}, exp_moves);
        check_val("stat_suppressed", {16'd0, stat_suppressed}, exp_supp);
`endif
        legal = (op == MV) || (op == CM);
        acc   = v && e_ready;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (e_we) void'(q.pop_front());
            if (acc && legal && c && (rd != 5'd0)) q.push_back(ent_t'{rd, d});
        end
        if (e_we && exp_moves < 65535) exp_moves++;
        if (acc && legal && !c && exp_supp < 65535) exp_supp++;
        exp_illegal = acc && !legal;
    endtask

    task automatic idle(input logic st, input logic [4:0] hz);
        step(1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, st, hz);
    endtask

    initial begin
        // Reset state while rst is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check_val("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check_val("rst_wdata", rf_wdata, 32'd0);
        check_val("rst_hz_hit", {31'd0, hz_hit}, 32'd0);
        check_val("rst_hz_data", hz_data, 32'd0);
        check_val("rst_illegal", {31'd0, illegal_op}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);

        // Single CMOV commits the following cycle
        step(1'b1, CM, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0);
        idle(1'b0, 5'd5);
        idle(1'b0, 5'd5);

        // Suppressed CMOV and rd=0 never write
        step(1'b1, CM, 1'b0, 5'd7, 32'h1234, 1'b0, 1'b0, 5'd0);
        step(1'b1, MV, 1'b1, 5'd0, 32'h5555, 1'b0, 1'b0, 5'd0);
        idle(1'b0, 5'd7);
        idle(1'b0, 5'd0);

        // Stalled back-to-back MOVEs: third held off until a slot frees
        step(1'b1, MV, 1'b1, 5'd1, 32'h101, 1'b0, 1'b1, 5'd0);
        step(1'b1, MV, 1'b1, 5'd2, 32'h102, 1'b0, 1'b1, 5'd0);
        step(1'b1, MV, 1'b1, 5'd3, 32'h103, 1'b0, 1'b1, 5'd0);
        step(1'b1, MV, 1'b1, 5'd3, 32'h103, 1'b0, 1'b0, 5'd0);
        step(1'b1, MV, 1'b1, 5'd3, 32'h103, 1'b0, 1'b0, 5'd0);
        idle(1'b0, 5'd3);
        idle(1'b0, 5'd0);

        // Youngest match wins in the hazard lookup
        step(1'b1, CM, 1'b1, 5'd4, 32'd11, 1'b0, 1'b1, 5'd4);
        step(1'b1, MV, 1'b1, 5'd4, 32'd22, 1'b0, 1'b1, 5'd4);
        idle(1'b1, 5'd4);
        idle(1'b1, 5'd0);

        // Flush on a full queue with a request pending
        step(1'b1, MV, 1'b1, 5'd9, 32'd99, 1'b1, 1'b1, 5'd4);
        idle(1'b0, 5'd4);
        idle(1'b0, 5'd9);

        // Illegal opcode pulses for exactly one cycle
        step(1'b1, 6'b000000, 1'b1, 5'd6, 32'd66, 1'b0, 1'b0, 5'd0);
        idle(1'b0, 5'd6);
        idle(1'b0, 5'd6);

        // Reset mid-drain drops the write enable at once and discards the queue
        step(1'b1, MV, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b1, 5'd0);
        step(1'b1, MV, 1'b1, 5'd11, 32'hB0, 1'b0, 1'b1, 5'd0);
        @(negedge clk);
        req_valid = 1'b0; rf_stall = 1'b0; hz_raddr = 5'd11;
        #1;
        check_val("pre_rst_we", {31'd0, rf_we}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_we", {31'd0, rf_we}, 32'd0);
        check_val("mid_rst_hz", {31'd0, hz_hit}, 32'd0);
        q.delete();
        exp_illegal = 1'b0;
        exp_moves = 0;
        exp_supp = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0, 5'd10);
        idle(1'b0, 5'd11);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [5:0] op;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)      op = MV;
            else if (sel < 8) op = CM;
            else              op = 6'($urandom);
            step(($urandom_range(0, 3) != 0), op, ($urandom_range(0, 4) != 0),
                 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmov_writeback.md
# cmov_writeback

Register-file commit stage for MOVE/CMOV instructions in the Mini RISC datapath. Accepts a per-instruction request carrying the move-enable decision produced by the conditional-move comparator, buffers qualifying writes in a 2-entry queue, and drains them into the shared register-file write port when it is not stalled. Provides a hazard/forward lookup so decode can see writes still pending in the queue.

## Interface
- No parameters; depth fixed at 2, data width 32, register address width 5.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present this cycle
- req_ready  output  1  block can accept a request
- req_opcode  input  6  instruction opcode; MOVE = 6'b110000, CMOV = 6'b110001
- req_cmov  input  1  move-enable decision from the comparator (1 = write)
- req_rd  input  5  destination register
- req_data  input  32  value to write (rs data)
- flush  input  1  synchronous queue clear (branch/exception)
- rf_stall  input  1  write port taken by ALU writeback this cycle
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  write address
- rf_wdata  output  32  write data
- hz_raddr  input  5  register queried by decode
- hz_hit  output  1  pending queued write to hz_raddr
- hz_data  output  32  data of youngest matching pending write
- illegal_op  output  1  registered one-cycle pulse: accepted request with non-MOVE/CMOV opcode
- stat_moves  output  16  (CMOV_STATS_EN only) committed writes
- stat_suppressed  output  16  (CMOV_STATS_EN only) requests dropped by req_cmov = 0

## Operation
- Queue: 2 entries {rd, data}, head/tail pointers, count 0..2; states EMPTY (0), ONE (1), FULL (2).
- Accept = req_valid && req_ready. req_ready = (count != 2) && !flush; independent of req_valid.
- On accept: enqueue iff opcode is MOVE or CMOV, req_cmov = 1 and req_rd != 0. MOVE with req_cmov = 0 is still dropped (comparator drives 1 for MOVE). rd = 0 writes are dropped silently. Other opcodes dropped and raise illegal_op next cycle.
- Drain: rf_we = (count != 0) && !rf_stall; rf_waddr/rf_wdata = head entry (combinational from head). Dequeue on every cycle rf_we = 1.
- Simultaneous enqueue + dequeue in ONE: count stays 1, new entry becomes head next cycle. In EMPTY, enqueue and drain never coincide (no bypass).
- Transitions: EMPTY→ONE on enqueue; ONE→FULL on enqueue w/o dequeue; ONE→EMPTY on dequeue w/o enqueue; FULL→ONE on dequeue.
- flush: count ← 0, pointers ← 0 at next edge; has priority over enqueue and dequeue in same cycle; rf_we still reflects pre-flush head that cycle and that write is performed by the register file.
- Hazard: hz_hit = hz_raddr != 0 and some valid entry matches; hz_data = youngest (tail-side) match, else 0. Purely combinational on queue contents.
- Pointer wrap: 1-bit pointers wrap 1→0.

## Timing
- Reset (async): count 0, pointers 0, rf_we 0, rf_waddr 0, rf_wdata 0, hz_hit 0, hz_data 0, illegal_op 0, stats 0; req_ready 1 after reset deasserts.
- Latency: request accepted at edge N, queue empty, rf_stall low → rf_we high during cycle N+1.
- Throughput: one write per cycle sustained when rf_stall low.
- Reset mid-operation discards queued writes; none are issued afterwards.

## Configuration
- CMOV_STATS_EN defined: stat_moves increments on each rf_we cycle, stat_suppressed on each accepted MOVE/CMOV with req_cmov = 0; both saturate at 16'hFFFF, cleared by rst only (not flush).
- Undefined: stat ports and counters absent from the module.

## Test plan
- CMOV rd=5, data=32'hDEADBEEF, req_cmov=1, rf_stall=0 → next cycle rf_we=1, waddr=5, wdata=32'hDEADBEEF; queue empty after.
- CMOV rd=7, req_cmov=0 → no rf_we ever; stat_suppressed=1 with CMOV_STATS_EN.
- rf_stall held high, three back-to-back MOVEs rd=1,2,3 → req_ready low after two; release stall → writes to 1 then 2 then 3 in consecutive cycles.
- Queue holds rd=4 data 11 then rd=4 data 22, hz_raddr=4 → hz_hit=1, hz_data=22; hz_raddr=0 → hz_hit=0.
- FULL queue, flush=1 with req_valid=1 → req_ready=0, count 0 next cycle, no further rf_we; assert rst mid-drain → rf_we 0 immediately.
- opcode 6'b000000 with req_valid=1 → accepted, illegal_op pulses one cycle, no write.
